// File: rtl/can_rx_pkg.sv
// Shared types and helpers for the CAN receive FIFO write-side controller.
package can_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    DATA  = 2'd2,
    BURST = 2'd3
  } state_e;

  localparam int unsigned HDR_WORDS = 2;

  // First FIFO word of every message; dlc lands in bits 31:28, trunc in bit 22.
  typedef struct packed {
    logic [3:0]  dlc;
    logic        fdf;
    logic        brs;
    logic        esi;
    logic        ide;
    logic        rtr;
    logic        trunc;
    logic [21:0] rsvd;
  } word0_t;

  // Payload length for a DLC; classic frames never exceed 8 bytes.
  function automatic logic [6:0] dlc_to_bytes(input logic [3:0] dlc, input logic fdf);
    logic [6:0] n;
    if (dlc <= 4'd8) begin
      n = 7'(dlc);
    end else if (!fdf) begin
      n = 7'd8;
    end else begin
      case (dlc)
        4'd9:    n = 7'd12;
        4'd10:   n = 7'd16;
        4'd11:   n = 7'd20;
        4'd12:   n = 7'd24;
        4'd13:   n = 7'd32;
        4'd14:   n = 7'd48;
        default: n = 7'd64;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/can_rx_stage_buf.sv
// Staging buffer for one frame's data: byte-addressed write, word read, one-cycle clear.
module can_rx_stage_buf #(
  parameter int unsigned DEPTH = 13
) (
  input  logic        clk,
  input  logic        clr_i,
  input  logic        we_i,
  input  logic [5:0]  byte_addr_i,
  input  logic [7:0]  byte_i,
  input  logic [3:0]  rd_idx_i,
  output logic [31:0] rd_word_o
);

  logic [31:0] mem_q [DEPTH];

  // Contents are don't-care after reset; every frame starts with a clear.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(byte_addr_i[5:2]) < DEPTH)) begin
      mem_q[byte_addr_i[5:2]][{byte_addr_i[1:0], 3'b000} +: 8] <= byte_i;
    end
  end

  assign rd_word_o = (32'(rd_idx_i) < DEPTH) ? mem_q[rd_idx_i] : 32'd0;

endmodule

// File: rtl/can_rx_fifo_ctrl.sv
// Receive FIFO write sequencer: stages a frame, bursts it into the FIFO on accept,
// and spaces host release commands into FIFO release pulses.
module can_rx_fifo_ctrl
  import can_rx_pkg::*;
#(
  parameter int unsigned MAX_DATA_WORDS = 13,
  parameter int unsigned DROP_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reset_mode_i,
  input  logic                  frame_start_i,
  input  logic                  hdr_valid_i,
  input  logic [28:0]           hdr_id_i,
  input  logic                  hdr_ide_i,
  input  logic                  hdr_rtr_i,
  input  logic                  hdr_fdf_i,
  input  logic                  hdr_brs_i,
  input  logic                  hdr_esi_i,
  input  logic [3:0]            hdr_dlc_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  input  logic                  frame_ok_i,
  input  logic                  frame_err_i,
  input  logic                  accept_i,
  input  logic                  release_cmd_i,
  input  logic                  info_empty_i,
  output logic                  fifo_wr_o,
  output logic [31:0]           fifo_data_o,
  output logic                  release_buffer_o,
  output logic                  rx_busy_o,
  output logic                  stored_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int unsigned MAX_BYTES = 4 * MAX_DATA_WORDS;

  state_e                state_q, state_d;
  logic [6:0]            byte_cnt_q, byte_cnt_d;
  logic [6:0]            nbytes_q, nbytes_d;
  logic [3:0]            total_q, total_d;
  logic [3:0]            idx_q, idx_d;
  word0_t                word0_q, word0_d;
  logic [28:0]           id_q, id_d;
  logic                  fifo_wr_q, fifo_wr_d;
  logic [31:0]           fifo_data_q, fifo_data_d;
  logic                  stored_q, stored_d;
  logic                  rx_busy_q;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  pending_q, pending_d;
  logic                  release_q, release_d;

  logic                  buf_clr_c, buf_we_c;
  logic [31:0]           rd_word_c;
  logic [6:0]            hdr_nbytes_c, hdr_ndw_c;

  can_rx_stage_buf #(.DEPTH(MAX_DATA_WORDS)) u_stage_buf (
    .clk         (clk),
    .clr_i       (buf_clr_c),
    .we_i        (buf_we_c),
    .byte_addr_i (byte_cnt_q[5:0]),
    .byte_i      (byte_data_i),
    .rd_idx_i    (idx_q - 4'(HDR_WORDS)),
    .rd_word_o   (rd_word_c)
  );

  // Header-derived payload size and number of stored data words.
  always_comb begin
    hdr_nbytes_c = hdr_rtr_i ? 7'd0 : dlc_to_bytes(hdr_dlc_i, hdr_fdf_i);
    hdr_ndw_c    = (hdr_nbytes_c + 7'd3) >> 2;
    if (hdr_ndw_c > 7'(MAX_DATA_WORDS)) begin
      hdr_ndw_c = 7'(MAX_DATA_WORDS);
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    nbytes_d    = nbytes_q;
    total_d     = total_q;
    idx_d       = idx_q;
    word0_d     = word0_q;
    id_d        = id_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = 32'd0;
    stored_d    = 1'b0;
    drop_d      = drop_q;
    buf_clr_c   = 1'b0;
    buf_we_c    = (state_q == DATA) && byte_valid_i && (byte_cnt_q < nbytes_q) &&
                  (byte_cnt_q < 7'(MAX_BYTES));

    case (state_q)
      IDLE: begin
        if (frame_start_i) begin
          buf_clr_c  = 1'b1;
          byte_cnt_d = 7'd0;
          state_d    = HDR;
        end
      end
      HDR: begin
        if (frame_start_i) begin
          buf_clr_c  = 1'b1;
          byte_cnt_d = 7'd0;
        end else if (frame_err_i || frame_ok_i) begin
          state_d = IDLE;
        end else if (hdr_valid_i) begin
          word0_d  = '{dlc: hdr_dlc_i, fdf: hdr_fdf_i, brs: hdr_brs_i, esi: hdr_esi_i,
                       ide: hdr_ide_i, rtr: hdr_rtr_i,
                       trunc: (hdr_nbytes_c > 7'(MAX_BYTES)), rsvd: 22'd0};
          id_d     = hdr_id_i;
          nbytes_d = hdr_nbytes_c;
          total_d  = 4'(7'(HDR_WORDS) + hdr_ndw_c);
          state_d  = DATA;
        end
      end
      DATA: begin
        if (frame_start_i) begin
          buf_clr_c  = 1'b1;
          byte_cnt_d = 7'd0;
          state_d    = HDR;
        end else if (frame_err_i) begin
          state_d = IDLE;
        end else if (frame_ok_i) begin
          if (accept_i) begin
            // Word 0 goes out on the frame_ok edge; the rest follow back to back.
            fifo_wr_d   = 1'b1;
            fifo_data_d = word0_q;
            idx_d       = 4'd1;
            state_d     = BURST;
          end else begin
            state_d = IDLE;
          end
        end else if (byte_valid_i && (byte_cnt_q != 7'd64)) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
        end
      end
      BURST: begin
        if (frame_start_i && (drop_q != '1)) begin
          drop_d = drop_q + 1'b1;
        end
        if (idx_q < total_q) begin
          fifo_wr_d   = 1'b1;
          fifo_data_d = (idx_q == 4'd1) ? {3'b000, id_q} : rd_word_c;
          idx_d       = idx_q + 4'd1;
        end else begin
          stored_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Release pulses are spaced by at least one idle cycle so the FIFO count settles.
    release_d = pending_q && !info_empty_i && !release_q;
    if (release_d || (pending_q && info_empty_i)) begin
      pending_d = release_cmd_i;
    end else begin
      pending_d = pending_q || release_cmd_i;
    end

    if (reset_mode_i) begin
      state_d     = IDLE;
      fifo_wr_d   = 1'b0;
      fifo_data_d = 32'd0;
      stored_d    = 1'b0;
      drop_d      = drop_q;
      pending_d   = 1'b0;
      release_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= 7'd0;
      nbytes_q    <= 7'd0;
      total_q     <= 4'd0;
      idx_q       <= 4'd0;
      word0_q     <= '0;
      id_q        <= 29'd0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= 32'd0;
      stored_q    <= 1'b0;
      rx_busy_q   <= 1'b0;
      drop_q      <= '0;
      pending_q   <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      nbytes_q    <= nbytes_d;
      total_q     <= total_d;
      idx_q       <= idx_d;
      word0_q     <= word0_d;
      id_q        <= id_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
      stored_q    <= stored_d;
      rx_busy_q   <= (state_d != IDLE);
      drop_q      <= drop_d;
      pending_q   <= pending_d;
      release_q   <= release_d;
    end
  end

  assign fifo_wr_o        = fifo_wr_q;
  assign fifo_data_o      = fifo_data_q;
  assign release_buffer_o = release_q;
  assign rx_busy_o        = rx_busy_q;
  assign stored_o         = stored_q;
  assign drop_cnt_o       = drop_q;

endmodule

// File: tb/tb_can_rx_fifo_ctrl.sv
// Directed bench for can_rx_fifo_ctrl: frame bursts, discards, drop count, release spacing, resets.
module tb_can_rx_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reset_mode_i, frame_start_i, hdr_valid_i;
  logic [28:0] hdr_id_i;
  logic        hdr_ide_i, hdr_rtr_i, hdr_fdf_i, hdr_brs_i, hdr_esi_i;
  logic [3:0]  hdr_dlc_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        frame_ok_i, frame_err_i, accept_i, release_cmd_i, info_empty_i;
  logic        fifo_wr_o;
  logic [31:0] fifo_data_o;
  logic        release_buffer_o, rx_busy_o, stored_o;
  logic [7:0]  drop_cnt_o;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] words [16];
  int          n_wr;
  logic        stored_end, stored_any;
  logic [31:0] data_low;
  logic [5:0]  rel_seq;
  logic        rel_any;

  always #5 clk = ~clk;

  can_rx_fifo_ctrl #(.MAX_DATA_WORDS(13), .DROP_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .reset_mode_i(reset_mode_i), .frame_start_i(frame_start_i),
    .hdr_valid_i(hdr_valid_i), .hdr_id_i(hdr_id_i), .hdr_ide_i(hdr_ide_i),
    .hdr_rtr_i(hdr_rtr_i), .hdr_fdf_i(hdr_fdf_i), .hdr_brs_i(hdr_brs_i),
    .hdr_esi_i(hdr_esi_i), .hdr_dlc_i(hdr_dlc_i), .byte_valid_i(byte_valid_i),
    .byte_data_i(byte_data_i), .frame_ok_i(frame_ok_i), .frame_err_i(frame_err_i),
    .accept_i(accept_i), .release_cmd_i(release_cmd_i), .info_empty_i(info_empty_i),
    .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o), .release_buffer_o(release_buffer_o),
    .rx_busy_o(rx_busy_o), .stored_o(stored_o), .drop_cnt_o(drop_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [28:0] id, input logic ide, input logic rtr,
                          input logic fdf, input logic brs, input logic esi, input logic [3:0] dlc);
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    hdr_id_i = id; hdr_ide_i = ide; hdr_rtr_i = rtr;
    hdr_fdf_i = fdf; hdr_brs_i = brs; hdr_esi_i = esi; hdr_dlc_i = dlc;
    hdr_valid_i = 1'b1;
    tick();
    hdr_valid_i = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int base, input int step);
    for (int k = 0; k < n; k++) begin
      byte_valid_i = 1'b1;
      byte_data_i  = 8'(base + k * step);
      tick();
    end
    byte_valid_i = 1'b0;
  endtask

  task automatic end_ok(input logic acc);
    frame_ok_i = 1'b1;
    accept_i   = acc;
    tick();
    frame_ok_i = 1'b0;
    accept_i   = 1'b0;
  endtask

  // Records one burst; optionally injects frame_start or reset_mode on a given burst cycle.
  task automatic collect(input int fs_at, input int rm_at);
    n_wr = 0; stored_end = 1'b0; stored_any = 1'b0; data_low = 32'hdead_beef;
    for (int c = 0; c < 40; c++) begin
      frame_start_i = (c == fs_at);
      reset_mode_i  = (c == rm_at);
      stored_any    = stored_any | stored_o;
      if (fifo_wr_o) begin
        if (n_wr < 16) words[n_wr] = fifo_data_o;
        n_wr++;
      end else if (n_wr > 0) begin
        stored_end = stored_o;
        data_low   = fifo_data_o;
        break;
      end
      tick();
    end
    frame_start_i = 1'b0;
    reset_mode_i  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    reset_mode_i = 0; frame_start_i = 0; hdr_valid_i = 0; hdr_id_i = '0;
    hdr_ide_i = 0; hdr_rtr_i = 0; hdr_fdf_i = 0; hdr_brs_i = 0; hdr_esi_i = 0; hdr_dlc_i = '0;
    byte_valid_i = 0; byte_data_i = '0; frame_ok_i = 0; frame_err_i = 0; accept_i = 0;
    release_cmd_i = 0; info_empty_i = 1'b1;
    repeat (3) tick();
    check_eq("rst_outputs", {fifo_wr_o, release_buffer_o, rx_busy_o, stored_o},  32'd0);
    check_eq("rst_data", fifo_data_o, 32'd0);
    check_eq("rst_drop", 32'(drop_cnt_o), 32'd0);
    rst = 1'b0;
    tick();

    // Classic frame, 3 bytes
    send_hdr(29'h123, 0, 0, 0, 0, 0, 4'd3);
    check_eq("cls_busy", 32'(rx_busy_o), 32'd1);
    send_bytes(3, 8'hAA, 8'h11);
    end_ok(1'b1);
    collect(-1, -1);
    check_eq("cls_nwr", n_wr, 3);
    check_eq("cls_w0", words[0], 32'h3000_0000);
    check_eq("cls_w1", words[1], 32'h0000_0123);
    check_eq("cls_w2", words[2], 32'h00CC_BBAA);
    check_eq("cls_stored", 32'(stored_end), 32'd1);
    check_eq("cls_data_idle", data_low, 32'd0);
    tick();
    check_eq("cls_busy_end", 32'(rx_busy_o), 32'd0);

    // FD frame, 64 bytes, truncated to 13 data words
    send_hdr(29'h1ABCDEF, 1, 0, 1, 1, 0, 4'd15);
    send_bytes(64, 0, 1);
    end_ok(1'b1);
    collect(-1, -1);
    check_eq("fd_nwr", n_wr, 15);
    check_eq("fd_w0", words[0], 32'hFD40_0000);
    check_eq("fd_w1", words[1], 32'h01AB_CDEF);
    check_eq("fd_w2", words[2], 32'h0302_0100);
    check_eq("fd_w14", words[14], 32'h3332_3130);
    tick();

    // RTR: header words only
    send_hdr(29'h7FF, 0, 1, 0, 0, 0, 4'd8);
    send_bytes(2, 8'h55, 1);
    end_ok(1'b1);
    collect(-1, -1);
    check_eq("rtr_nwr", n_wr, 2);
    check_eq("rtr_w0", words[0], 32'h8080_0000);
    check_eq("rtr_w1", words[1], 32'h0000_07FF);
    tick();

    // Classic frame with DLC 12 clamps to 8 bytes
    send_hdr(29'h040, 0, 0, 0, 0, 0, 4'd12);
    send_bytes(10, 8'h10, 1);
    end_ok(1'b1);
    collect(-1, -1);
    check_eq("clamp_nwr", n_wr, 4);
    check_eq("clamp_w0", words[0], 32'hC000_0000);
    check_eq("clamp_w2", words[2], 32'h1312_1110);
    check_eq("clamp_w3", words[3], 32'h1716_1514);
    tick();

    // Rejected by acceptance filter
    send_hdr(29'h321, 0, 0, 0, 0, 0, 4'd1);
    send_bytes(1, 8'h77, 0);
    end_ok(1'b0);
    collect(-1, -1);
    check_eq("rej_nwr", n_wr, 0);
    check_eq("rej_stored", 32'(stored_any), 32'd0);
    check_eq("rej_busy", 32'(rx_busy_o), 32'd0);

    // Error mid-DATA
    send_hdr(29'h222, 0, 0, 0, 0, 0, 4'd4);
    send_bytes(2, 8'h01, 1);
    check_eq("err_busy_pre", 32'(rx_busy_o), 32'd1);
    frame_err_i = 1'b1;
    tick();
    frame_err_i = 1'b0;
    check_eq("err_busy_post", 32'(rx_busy_o), 32'd0);
    collect(-1, -1);
    check_eq("err_nwr", n_wr, 0);

    // Frame start during burst is dropped; back-to-back frames
    send_hdr(29'h0AA, 0, 0, 0, 0, 0, 4'd1);
    send_bytes(1, 8'h5A, 0);
    end_ok(1'b1);
    collect(1, -1);
    check_eq("drop_nwr", n_wr, 3);
    check_eq("drop_w2", words[2], 32'h0000_005A);
    check_eq("drop_stored", 32'(stored_end), 32'd1);
    check_eq("drop_gap", 32'(fifo_wr_o), 32'd0);
    check_eq("drop_cnt", 32'(drop_cnt_o), 32'd1);
    send_hdr(29'h055, 0, 0, 0, 0, 0, 4'd2);
    send_bytes(2, 8'h01, 1);
    end_ok(1'b1);
    collect(-1, -1);
    check_eq("b2b_nwr", n_wr, 3);
    check_eq("b2b_w1", words[1], 32'h0000_0055);
    check_eq("b2b_w2", words[2], 32'h0000_0201);
    tick();

    // reset_mode on burst cycle 2
    send_hdr(29'h100, 0, 0, 0, 0, 0, 4'd8);
    send_bytes(8, 8'h20, 1);
    end_ok(1'b1);
    collect(-1, 2);
    check_eq("rm_nwr", n_wr, 3);
    check_eq("rm_stored", 32'(stored_end), 32'd0);
    check_eq("rm_busy", 32'(rx_busy_o), 32'd0);
    check_eq("rm_drop_hold", 32'(drop_cnt_o), 32'd1);
    tick();

    // Release spacing with back-to-back commands
    info_empty_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      release_cmd_i = (k < 3);
      tick();
      rel_seq[k] = release_buffer_o;
    end
    release_cmd_i = 1'b0;
    check_eq("rel_seq", 32'(rel_seq), 32'h0000_000A);

    // Pending dropped while FIFO is empty
    info_empty_i  = 1'b1;
    release_cmd_i = 1'b1;
    tick();
    release_cmd_i = 1'b0;
    tick();
    info_empty_i = 1'b0;
    rel_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      rel_any = rel_any | release_buffer_o;
    end
    check_eq("rel_empty_clear", 32'(rel_any), 32'd0);
    info_empty_i = 1'b1;

    // Asynchronous reset mid-DATA
    send_hdr(29'h333, 0, 0, 0, 0, 0, 4'd4);
    send_bytes(2, 8'h01, 1);
    check_eq("arst_busy_pre", 32'(rx_busy_o), 32'd1);
    #3 rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(rx_busy_o), 32'd0);
    check_eq("arst_drop", 32'(drop_cnt_o), 32'd0);
    check_eq("arst_wr", {fifo_wr_o, stored_o, release_buffer_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
